// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the alu_seq block and its core.
package alu_seq_pkg;

  typedef enum logic [4:0] {
    OP_AND = 5'd0,
    OP_OR  = 5'd1,
    OP_ADD = 5'd2,
    OP_INC = 5'd3,
    OP_DEC = 5'd4,
    OP_NOT = 5'd5,
    OP_SUB = 5'd6,
    OP_XOR = 5'd7,
    OP_SHL = 5'd8,
    OP_SHR = 5'd9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [4:0] OP_LAST = 5'd9;

  function automatic logic op_is_shift(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic op_takes_carry(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle ALU: logic ops, add/sub with carry-in, inc/dec/not
// on a selectable operand. Opcodes outside 0..7 produce zero.
import alu_seq_pkg::*;

module alu_seq_core #(
  parameter int ANCHO = 4
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [2:0]       op,
  input  logic             sel,
  input  logic             cin,
  output logic [ANCHO-1:0] result,
  output logic             carry
);

  logic [ANCHO-1:0] opnd;
  logic [ANCHO:0]   wide;

  // The extra MSB of 'wide' is carry-out for sums and the borrow for differences.
  always_comb begin
    opnd   = sel ? b : a;
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (opcode_e'({2'b00, op}))
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~opnd;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b} + {{ANCHO{1'b0}}, cin};
        result = wide[ANCHO-1:0];
        carry  = wide[ANCHO];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b} - {{ANCHO{1'b0}}, cin};
        result = wide[ANCHO-1:0];
        carry  = wide[ANCHO];
      end
      OP_INC: begin
        wide   = {1'b0, opnd} + (ANCHO+1)'(1);
        result = wide[ANCHO-1:0];
        carry  = wide[ANCHO];
      end
      OP_DEC: begin
        wide   = {1'b0, opnd} - (ANCHO+1)'(1);
        result = wide[ANCHO-1:0];
        carry  = wide[ANCHO];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops via alu_seq_core, serial bit-per-cycle
// shifts, held result until consumed. ALU_SEQ_CARRY_CHAIN_EN enables stored-carry chaining.
import alu_seq_pkg::*;

module alu_seq #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ANCHO-1:0] ALUA,
  input  logic [ANCHO-1:0] ALUB,
  input  logic [4:0]       ALUControl,
  input  logic [1:0]       ALUFlagIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANCHO-1:0] ALUResult,
  output logic             C,
  output logic             Z,
  output logic             err
);

  localparam int CW = $clog2(ANCHO + 1);

  state_e           state_q, state_d;
  logic [ANCHO-1:0] result_q, result_d;
  logic             c_q, c_d, z_q, z_d, err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d, fill_q, fill_d;

  logic [ANCHO-1:0] core_res;
  logic             core_c, cin, chain_ok, illegal;
  logic [CW-1:0]    cap;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic carry_q, carry_d;

  // Stored carry follows every consumed result except illegal requests.
  always_comb begin
    carry_d = carry_q;
    if (state_q == ST_HOLD && out_ready && !err_q) carry_d = c_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign chain_ok = op_takes_carry(ALUControl);
  assign cin      = ALUFlagIn[1] ? carry_q : ALUFlagIn[0];
`else
  assign chain_ok = 1'b0;
  assign cin      = ALUFlagIn[0];
`endif

  assign illegal = (ALUControl > OP_LAST) || (ALUFlagIn[1] && !chain_ok);
  assign cap     = (32'(ALUB) > ANCHO) ? CW'(ANCHO) : CW'(ALUB);

  alu_seq_core #(.ANCHO(ANCHO)) u_core (
    .a      (ALUA),
    .b      (ALUB),
    .op     (ALUControl[2:0]),
    .sel    (ALUFlagIn[0]),
    .cin    (cin),
    .result (core_res),
    .carry  (core_c)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          err_d = 1'b0;
          if (illegal) begin
            result_d = '0;
            c_d      = 1'b0;
            z_d      = 1'b1;
            err_d    = 1'b1;
            state_d  = ST_HOLD;
          end else if (op_is_shift(ALUControl)) begin
            // result_q doubles as the shift register while in SHIFT.
            result_d = ALUA;
            c_d      = 1'b0;
            z_d      = (ALUA == '0);
            dir_d    = (ALUControl == OP_SHR);
            fill_d   = ALUFlagIn[0];
            cnt_d    = cap;
            state_d  = (cap == '0) ? ST_HOLD : ST_SHIFT;
          end else begin
            result_d = core_res;
            c_d      = core_c;
            z_d      = (core_res == '0);
            state_d  = ST_HOLD;
          end
        end
      end
      ST_SHIFT: begin
        if (dir_q) begin
          result_d = {fill_q, result_q[ANCHO-1:1]};
          c_d      = result_q[0];
        end else begin
          result_d = {result_q[ANCHO-2:0], fill_q};
          c_d      = result_q[ANCHO-1];
        end
        z_d   = (result_d == '0);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign ALUResult = result_q;
  assign C         = c_q;
  assign Z         = z_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (ANCHO=4): driver pushes model results, monitor pops on
// each output handshake. Honours ALU_SEQ_CARRY_CHAIN_EN in the reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] ALUA, ALUB, ALUResult;
  logic [4:0] ALUControl;
  logic [1:0] ALUFlagIn;
  logic       C, Z, err;

  typedef struct {
    int acc;
    int lat;
    int op, a, b, fl;
    logic [3:0] res;
    logic c, z, e;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_carry = 0;
  int   stall_cnt = 0;
  bit   rand_ready = 0;

  alu_seq #(.ANCHO(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl), .ALUFlagIn(ALUFlagIn),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .C(C), .Z(Z), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each operation.
  function automatic exp_t ref_model(input int a, input int b, input int op, input int fl,
                                     inout int carry);
    exp_t e;
    int cin, x, n, s;
    bit chain_ok;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    chain_ok = (op == 2 || op == 6);
`else
    chain_ok = 0;
`endif
    e.op = op; e.a = a; e.b = b; e.fl = fl;
    e.acc = 0; e.lat = 1; e.c = 0; e.e = 0;
    s = 0;
    if (op > 9 || ((fl & 2) != 0 && !chain_ok)) begin
      e.res = 4'h0; e.z = 1; e.e = 1;
      return e;
    end
    cin = ((fl & 2) != 0) ? carry : (fl & 1);
    x   = ((fl & 1) != 0) ? b : a;
    n   = (b > 4) ? 4 : b;
    case (op)
      0: s = a & b;
      1: s = a | b;
      7: s = a ^ b;
      2: begin s = a + b + cin; e.c = (s > 15); end
      6: begin s = a - b - cin; e.c = (a < b + cin); end
      3: begin s = x + 1; e.c = (x == 15); end
      4: begin s = x - 1; e.c = (x == 0); end
      5: s = 15 - x;
      8: begin
        e.lat = 1 + n;
        if (n == 0) s = a;
        else begin
          s = (a << n) | (((fl & 1) != 0) ? ((1 << n) - 1) : 0);
          e.c = ((a >> (4 - n)) & 1) != 0;
        end
      end
      default: begin
        e.lat = 1 + n;
        if (n == 0) s = a;
        else begin
          s = (a >> n) | (((fl & 1) != 0) ? ((15 << (4 - n)) & 15) : 0);
          e.c = ((a >> (n - 1)) & 1) != 0;
        end
      end
    endcase
    e.res = 4'(s & 15);
    e.z   = (e.res == 4'h0);
    carry = e.c ? 1 : 0;
    return e;
  endfunction

  task automatic do_op(input int a, input int b, input int op, input int fl);
    int   w;
    exp_t e;
    @(negedge clk);
    ALUA = 4'(a); ALUB = 4'(b); ALUControl = 5'(op); ALUFlagIn = 2'(fl);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk(0, "accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = ref_model(a, b, op, fl, model_carry);
    e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    bit   seen = 0;
    bit   idle_chk = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        seen = 0;
        idle_chk = 0;
      end else begin
        if (idle_chk) begin
          chk(in_ready == 1'b1, "resume_in_ready", int'(in_ready), 1);
          idle_chk = 0;
        end
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (out_valid) begin
            if (!seen) begin
              seen = 1;
              chk(cyc - e.acc == e.lat, "latency", cyc - e.acc, e.lat);
            end
            chk({ALUResult, C, Z, err} == {e.res, e.c, e.z, e.e}, "result_res_c_z_err",
                int'({ALUResult, C, Z, err}), int'({e.res, e.c, e.z, e.e}));
            chk(in_ready == 1'b0, "hold_in_ready", int'(in_ready), 0);
            if (out_ready) begin
              $display("txn op=%0d a=%0h b=%0h fl=%0d -> res=%0h c=%0b z=%0b err=%0b lat=%0d",
                       e.op, e.a, e.b, e.fl, ALUResult, C, Z, err, e.lat);
              void'(exp_q.pop_front());
              seen = 0;
              idle_chk = 1;
            end
          end else if (cyc - e.acc > e.lat + 2) begin
            chk(0, "out_valid_timeout", cyc - e.acc, e.lat);
            void'(exp_q.pop_front());
            seen = 0;
          end
        end else if (out_valid) begin
          chk(0, "unexpected_out_valid", 1, 0);
        end
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0 && out_valid) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  endtask

  initial begin
    int  op, fl, w;
    bit  saw;
    in_valid = 1'b0; out_ready = 1'b1;
    ALUA = '0; ALUB = '0; ALUControl = '0; ALUFlagIn = '0;
    rst = 1'b0;
    fork
      monitor();
      ready_gen();
    join_none
    #1 rst = 1'b1;
    #1;
    chk({ALUResult, C, Z, err, out_valid} == 8'h0, "reset_outputs",
        int'({ALUResult, C, Z, err, out_valid}), 0);
    chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(4'hF, 4'h1, 2, 0);          // ADD wraps: 0, C=1, Z=1
    do_op(4'b1011, 2, 8, 1);          // SHL by 2 with fill 1
    do_op(4'b0110, 5, 9, 0);          // SHR capped at 4
    do_op(4'h9, 0, 8, 0);             // zero-length shift
    do_op(4'h3, 4'h5, 6, 1);          // SUB with borrow
    do_op(4'h0, 4'h7, 4, 0);          // DEC of zero on A
    do_op(4'h2, 4'hF, 3, 1);          // INC on B overflows
    do_op(4'hA, 4'h5, 5, 0);          // NOT
    stall_cnt = 3;
    do_op(4'hC, 4'hA, 7, 0);          // XOR held 3 cycles
    do_op(4'h6, 4'h3, 0, 0);          // accepted right after the stalled handshake
    do_op(4'h1, 4'h2, 31, 0);         // illegal opcode
    do_op(4'h1, 4'h2, 1, 2);          // OR with bit1 set: never permitted
    do_op(4'hF, 4'h1, 2, 0);
    do_op(4'h0, 4'h0, 2, 2);          // chained ADD (legal only with the macro)
    do_op(4'h0, 4'h0, 6, 2);

    // Reset in the middle of a 4-bit serial shift.
    do_op(4'b0110, 4, 9, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk({ALUResult, C, Z, err, out_valid} == 8'h0, "midshift_reset_outputs",
        int'({ALUResult, C, Z, err, out_valid}), 0);
    chk(in_ready == 1'b1, "midshift_reset_in_ready", int'(in_ready), 1);
    model_carry = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk(in_ready == 1'b1, "post_reset_in_ready", int'(in_ready), 1);
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    chk(!saw, "no_pulse_after_reset", int'(saw), 0);
    do_op(4'h7, 4'h8, 2, 3);

    rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 31) : $urandom_range(0, 9);
      fl = $urandom_range(0, 1) | (($urandom_range(0, 3) == 0) ? 2 : 0);
      do_op($urandom_range(0, 15), $urandom_range(0, 15), op, fl);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter ANCHO, default 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port ALUA  input  ANCHO  operand A.
REQ-007 SHALL have port ALUB  input  ANCHO  operand B; shift amount for shift ops.
REQ-008 SHALL have port ALUControl  input  5  opcode.
REQ-009 SHALL have port ALUFlagIn  input  2  bit0: carry-in / operand select / shift fill; bit1: use stored carry.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port ALUResult  output  ANCHO  registered result.
REQ-013 SHALL have port C  output  1  registered carry/borrow/last-shifted-out bit.
REQ-014 SHALL have port Z  output  1  registered zero flag, 1 when ALUResult == 0.
REQ-015 SHALL have port err  output  1  registered illegal-request flag.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, HOLD; in_ready = (state == IDLE); out_valid = (state == HOLD).
REQ-017 SHALL accept a request on in_valid && in_ready, capturing ALUA, ALUB, ALUControl, ALUFlagIn.
REQ-018 SHALL execute opcodes 0 AND, 1 OR, 2 ADD (A+B+cin), 3 INC, 4 DEC, 5 NOT, 6 SUB (A-B-cin), 7 XOR in one cycle: IDLE -> HOLD, out_valid asserted the cycle after acceptance.
REQ-019 SHALL select operand A for INC/DEC/NOT when ALUFlagIn[0]=0 and operand B when 1.
REQ-020 SHALL set C = carry out of MSB for ADD/INC, borrow (A < B+cin, or operand == 0 for DEC) for SUB/DEC, 0 for logic ops.
REQ-021 SHALL execute opcodes 8 SHL and 9 SHR serially, one bit per cycle in SHIFT, fill bit = ALUFlagIn[0], C = last bit shifted out.
REQ-022 SHALL cap the shift count at min(ALUB, ANCHO); shift latency = 1 + capped count cycles to out_valid.
REQ-023 SHALL, for shift with ALUB == 0, go IDLE -> HOLD with ALUResult = ALUA and C = 0.
REQ-024 SHALL hold ALUResult, C, Z, err stable in HOLD until out_valid && out_ready, then return to IDLE.
REQ-025 SHALL treat opcode > 9, or ALUFlagIn[1]=1 where not permitted, as illegal: IDLE -> HOLD, ALUResult = 0, C = 0, Z = 1, err = 1.
REQ-026 SHALL keep a stored-carry register updated with C at each completed operation (HOLD handshake), err operations excepted.

Reset
REQ-027 SHALL on rst force state IDLE, ALUResult = 0, C = 0, Z = 0, err = 0, stored carry = 0, shift counter = 0, independent of clk.
REQ-028 SHALL abandon any in-flight shift or held result on rst with no output pulse after release; first acceptance possible on the first edge after rst deasserts.

Configuration
REQ-029 SHALL, with ALU_SEQ_CARRY_CHAIN_EN defined, use the stored carry as cin for ADD/SUB when ALUFlagIn[1]=1 (multi-word chaining).
REQ-030 SHALL, without ALU_SEQ_CARRY_CHAIN_EN, treat ALUFlagIn[1]=1 as illegal for every opcode (REQ-025); stored carry register may be omitted.

Structure
REQ-031 SHALL place opcode enum (OP_AND..OP_SHR) and FSM state enum in package alu_seq_pkg.
REQ-032 SHALL implement single-cycle ops in combinational sub-module alu_seq_core; FSM, shifter and registers in alu_seq.

Verification (ANCHO = 4)
REQ-033 SHALL cover ADD A=4'hF B=4'h1 ALUFlagIn=0 -> next cycle out_valid=1, ALUResult=4'h0, C=1, Z=1.
REQ-034 SHALL cover SHL A=4'b1011 B=2 ALUFlagIn=2'b01 -> out_valid 3 cycles after accept, ALUResult=4'b1111, C=0.
REQ-035 SHALL cover SHR A=4'b0110 B=5 fill 0 -> capped at 4 shifts, out_valid after 5 cycles, ALUResult=0, C=0, Z=1.
REQ-036 SHALL cover out_ready low 3 cycles in HOLD -> outputs stable, in_ready=0; accept resumes the cycle after the handshake.
REQ-037 SHALL cover rst asserted mid-SHIFT -> all outputs 0 immediately, IDLE, in_ready=1 after release.
REQ-038 SHALL cover ALUControl=5'h1F -> err=1, ALUResult=0, Z=1; with macro, ADD 4'hF+4'h1 then ADD 0+0 ALUFlagIn=2'b10 -> ALUResult=4'h1.
